// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    // Defaults assume a 50 MHz system clock: 100 us inhibit, 15 ms edge watchdog.
    localparam int unsigned PS2_INHIBIT_CYC_DEF = 5000;
    localparam int unsigned PS2_TIMEOUT_CYC_DEF = 750000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a one-cycle
// pulse on each falling edge of the synchronized clock.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_i,
    input  logic data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic fall_o
);

    logic [1:0] clk_ff_q;
    logic [1:0] data_ff_q;
    logic       clk_prev_q;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_ff_q   <= 2'b11;
            data_ff_q  <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_ff_q   <= {clk_ff_q[0], clk_i};
            data_ff_q  <= {data_ff_q[0], data_i};
            clk_prev_q <= clk_ff_q[1];
        end
    end

    assign clk_sync_o  = clk_ff_q[1];
    assign data_sync_o = data_ff_q[1];
    assign fall_o      = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, frame shift
// on device clock edges, acknowledge capture and an edge watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = PS2_INHIBIT_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    // start is a request qualified by busy: it is taken only in a cycle with
    // busy=0, and data must be valid in that same cycle.
    input  logic       start,
    input  logic [7:0] data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error,
    output ps2_state_e dbg_state
);

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    logic clk_sync;
    logic data_sync;
    logic fall;

    ps2_line_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .clk_i       (ps2_clk_in),
        .data_i      (ps2_data_in),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .fall_o      (fall)
    );

    ps2_state_e       state_q, state_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       tx_q, tx_d;
    logic             drive_q, drive_d;
    logic             ack_smp_q, ack_smp_d;
    logic             ack_ok_q, ack_ok_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            inh_q     <= '0;
            wd_q      <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            drive_q   <= 1'b0;
            ack_smp_q <= 1'b0;
            ack_ok_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_q     <= inh_d;
            wd_q      <= wd_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            drive_q   <= drive_d;
            ack_smp_q <= ack_smp_d;
            ack_ok_q  <= ack_ok_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        inh_d     = inh_q;
        wd_d      = wd_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        drive_d   = drive_q;
        ack_smp_d = ack_smp_q;
        ack_ok_d  = ack_ok_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        // Watchdog on device clock edges; any state below may still override.
        if (state_q inside {SHIFT, ACK, WAIT_IDLE}) begin
            if (fall) begin
                wd_d = '0;
            end else if (wd_q == WD_LAST) begin
                wd_d    = '0;
                drive_d = 1'b0;
                error_d = 1'b1;
                state_d = IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                inh_d = '0;
                wd_d  = '0;
                bit_d = '0;
                // done/error cycles still report busy, so start is ignored there.
                if (start && !done_q && !error_q) begin
                    tx_d    = {odd_parity(data), data};
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    inh_d   = '0;
                    state_d = RTS;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            RTS: begin
                drive_d = 1'b1;
                bit_d   = '0;
                wd_d    = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Shifting in ones makes the 10th edge present the stop bit.
                if (fall) begin
                    drive_d = ~tx_q[0];
                    tx_d    = {1'b1, tx_q[8:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    ack_smp_d = ~data_sync;
                    state_d   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    ack_ok_d = ack_smp_q;
                    done_d   = 1'b1;
                    error_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == RTS);
    assign ps2_data_oe = (state_q == RTS) || ((state_q == SHIFT) && drive_q);
    assign busy        = (state_q != IDLE) || done_q || error_q;
    assign done        = done_q;
    assign ack_ok      = ack_ok_q;
    assign error       = error_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and randomized checks of the PS/2 host transmitter against a
// bit-level device model and a frame-level reference model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       error;
    ps2_state_e dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    logic [0:0] exp_q[$];

    // Open-collector lines: low if either side pulls.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYC (INHIBIT),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data        (data),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .error       (error),
        .dbg_state   (dbg_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: start 0, data LSB first, odd parity, stop 1.
    task automatic model_frame(input logic [7:0] b);
        int ones;
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i]);
            ones += int'(b[i]);
        end
        exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        exp_q.push_back(1'b1);
    endtask

    task automatic score_bit(input logic v);
        if (exp_q.size() == 0) begin
            check("frame_extra_bit", 32'd1, 32'd0);
        end else begin
            check("frame_bit", {31'd0, v}, {31'd0, exp_q.pop_front()});
        end
    endtask

    // Driver tasks
    task automatic issue_start(input logic [7:0] b);
        data  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("clk_oe_after_start", ps2_clk_oe, 1);
    endtask

    task automatic preamble();
        int n;
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 4 * INHIBIT) begin
            n++;
            tick();
        end
        check("inhibit_len", n, INHIBIT);
        check("rts_clk_oe", ps2_clk_oe, 1);
        check("rts_data_oe", ps2_data_oe, 1);
        tick();
        check("shift_clk_oe", ps2_clk_oe, 0);
        check("shift_data_oe", ps2_data_oe, 1);
        repeat (10) tick();
    endtask

    // Device model: samples start at the first fall, then one bit per rise.
    task automatic dev_clock(input int n_edges, input bit do_ack, input bit poke);
        for (int i = 1; i <= n_edges; i++) begin
            if (i == 1) score_bit(ps2_data_in);
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) tick();
            dev_clk_low = 1'b0;
            if (i == 11) begin
                dev_data_low = 1'b0;
                return;
            end
            score_bit(ps2_data_in);
            if (i == 3 && poke) begin
                data  = 8'hA5;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            repeat (HALF / 2) tick();
            if (i == 10 && do_ack) dev_data_low = 1'b1;
            repeat (HALF / 2) tick();
        end
    endtask

    task automatic wait_done(input bit exp_ack, input bit start_at_done);
        int n;
        n = 0;
        while (!done && !error && n < 100) begin
            n++;
            tick();
        end
        check("done_pulse", done, 1);
        check("error_at_done", error, 0);
        check("ack_ok", ack_ok, exp_ack);
        check("busy_at_done", busy, 1);
        check("oe_released_at_done", {ps2_clk_oe, ps2_data_oe}, 0);
        if (start_at_done) begin
            data  = 8'h3C;
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        tick();
        check("no_restart_after_done", {busy, ps2_clk_oe}, 0);
        check("ack_ok_hold", ack_ok, exp_ack);
    endtask

    task automatic full_frame(input logic [7:0] b, input bit do_ack, input bit poke,
                              input bit start_at_done);
        model_frame(b);
        issue_start(b);
        preamble();
        dev_clock(11, do_ack, poke);
        check("frame_len", exp_q.size(), 0);
        wait_done(do_ack, start_at_done);
        repeat (5) tick();
    endtask

    initial begin
        int gap;
        int n;
        bit saw_done;
        bit saw_err;
        logic [7:0] rb;
        bit ra;

        // Reset values
        repeat (3) tick();
        check("reset_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, error}, 0);
        check("reset_state", dbg_state, IDLE);
        reset = 1'b0;
        repeat (3) tick();

        // Directed frames from the test plan
        full_frame(8'hED, 1'b1, 1'b0, 1'b0);
        full_frame(8'h00, 1'b1, 1'b0, 1'b0);
        full_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        full_frame(8'h01, 1'b1, 1'b0, 1'b0);
        full_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        full_frame(8'h3E, 1'b1, 1'b1, 1'b0);

        // Randomized bytes and acknowledge behaviour
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            full_frame(rb, ra, 1'b0, 1'b0);
        end

        // Device stops clocking after 4 edges
        model_frame(8'hC3);
        issue_start(8'hC3);
        preamble();
        dev_clock(4, 1'b0, 1'b0);
        saw_done = 1'b0;
        n = 0;
        while (!error && n < 2 * TIMEOUT) begin
            if (done) saw_done = 1'b1;
            n++;
            tick();
        end
        gap = cyc - last_fall_cyc;
        check("timeout_error", error, 1);
        check("timeout_gap_window", (gap >= TIMEOUT + 1 && gap <= TIMEOUT + 5) ? 1 : 0, 1);
        check("timeout_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
        tick();
        check("timeout_error_one_cycle", error, 0);
        check("timeout_busy_clear", busy, 0);
        repeat (20) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("timeout_no_done", saw_done, 0);
        exp_q.delete();

        // Reset in the middle of SHIFT
        model_frame(8'h00);
        issue_start(8'h00);
        preamble();
        dev_clock(3, 1'b0, 1'b0);
        check("pre_reset_data_oe", ps2_data_oe, 1);
        reset = 1'b1;
        #1;
        check("reset_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("reset_mid_busy", busy, 0);
        exp_q.delete();
        saw_done = 1'b0;
        saw_err  = 1'b0;
        repeat (5) begin
            tick();
            if (done) saw_done = 1'b1;
            if (error) saw_err = 1'b1;
        end
        reset = 1'b0;
        repeat (20) begin
            tick();
            if (done) saw_done = 1'b1;
            if (error) saw_err = 1'b1;
        end
        check("reset_mid_no_pulse", {saw_done, saw_err}, 0);
        full_frame(8'h96, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
